draw_screen_sequencer: RTL and testbench
========================================

Name: draw_screen_sequencer

Overview:
- Control stage directly upstream of the banner and background draw engines, and downstream-side owner of the VGA adapter's plot/x/y/colour inputs.
- On a stage-clear request, it runs the selected 80x40 stage-clear banner engine (stage 1 or stage 2) by releasing that engine's resetn. It gates plot onto the engine's valid pixels, then waits for the player's continue key.
- After the key, it redraws the full background through the background engine and returns to idle.
- Each engine is held in reset whenever it is not being drawn, because an engine that is left free-running re-arms itself after it reports done.

Parameters:
PLOT_LAG, 2, cycles after engine resetn release before the first valid pixel (1 delay cycle + 1 coordinate register; ROM q aligns with it)
HOLD_CYCLES, 2, minimum cycles an engine's resetn is held low before release
TIMEOUT_CYCLES, 50000000, auto-continue delay used only when BANNER_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
stage_clear_req  in  1  single-cycle request to show the stage-clear banner
stage_sel  in  1  0 = stage 1 banner, 1 = stage 2 banner; sampled with stage_clear_req
key_continue  in  1  player continue key, already synchronised, level
s1_done, s2_done, bg_done  in  1 each  done flags from the three engines
s1_x, s2_x, bg_x  in  8 each  engine x coordinates
s1_y, s2_y, bg_y  in  7 each  engine y coordinates
s1_colour, s2_colour, bg_colour  in  9 each  engine colours
s1_resetn, s2_resetn, bg_resetn  out  1 each  engine run enables (active-low reset to each engine)
vga_x  out  8  x coordinate to the VGA adapter
vga_y  out  7  y coordinate to the VGA adapter
vga_colour  out  9  colour to the VGA adapter
vga_plot  out  1  write enable to the VGA adapter
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse when the background redraw completes

Behaviour:
- Reset (asynchronous, resetn low) forces:
  - state IDLE;
  - all engine resetn outputs 0;
  - vga_plot 0, vga_x/y/colour 0;
  - busy 0, seq_done 0;
  - all counters 0;
  - the latched selection to 0.
- States: IDLE, HOLD_BNR, DRAW_BNR, WAIT_KEY, HOLD_BG, DRAW_BG, FINISH.
- IDLE:
  - On stage_clear_req, latch stage_sel into sel_r and go to HOLD_BNR.
  - A request arriving in any other state is ignored; it is not queued.
- HOLD_BNR and HOLD_BG:
  - All engine resetn outputs stay 0.
  - Count HOLD_CYCLES cycles, then go to DRAW_BNR or DRAW_BG respectively.
- DRAW_BNR:
  - Only the selected engine's resetn is 1 (s1_resetn if sel_r = 0, s2_resetn if sel_r = 1).
  - lag_cnt counts up from 0 and saturates at PLOT_LAG.
  - vga_plot = (lag_cnt == PLOT_LAG).
  - vga_x/y/colour are a combinational mux of the selected engine's outputs.
  - In a cycle where vga_plot = 1 and the selected done = 1, that pixel is still plotted. The FSM then goes to WAIT_KEY at the next edge and the engine resetn drops to 0 at that same edge.
  - Any done = 1 seen before lag_cnt reaches PLOT_LAG is stale and is ignored.
- WAIT_KEY:
  - vga_plot = 0.
  - On a rising edge of key_continue, go to HOLD_BG. A key already held on entry does not count; the bench must release and press again.
- DRAW_BG:
  - Same rules as DRAW_BNR, but using the bg_* signals and bg_resetn. Exit on bg_done to FINISH.
- FINISH:
  - seq_done = 1 for this one cycle, then the FSM returns to IDLE.
- Outside the DRAW states, vga_plot = 0 and vga_x/y/colour are 0.
- Pixel count: exactly the number of engine pixels plotted, i.e. 3200 for an 80x40 banner.
- Reset asserted mid-draw aborts immediately: plot drops and all engines are held in reset. No partial-state recovery is required.

Optional Feature:
- Macro: BANNER_TIMEOUT_EN.
- When defined: a 26-bit counter runs in WAIT_KEY and clears on state entry. The FSM leaves WAIT_KEY on a key rising edge or when the counter reaches TIMEOUT_CYCLES-1, whichever occurs first.
- When not defined: no counter exists and WAIT_KEY waits for the key indefinitely.

Test Plan:
- Reset mid-DRAW_BNR (about pixel 100) -> next cycle vga_plot = 0, s1_resetn = 0, s2_resetn = 0, bg_resetn = 0, busy = 0.
- stage_clear_req with stage_sel = 1 from IDLE, using an 80x40 engine model offset to (39,39) -> s2_resetn high and s1_resetn low throughout the banner; exactly 3200 plot cycles; first plotted pixel (39,39); last plotted pixel (118,78) with s2_done = 1; then WAIT_KEY.
- stage_sel = 0 path -> only s1_resetn toggles, 3200 plots; a stale s1_done = 1 during the lag cycles does not end the draw.
- key_continue held high on entry to WAIT_KEY -> no transition; release then press -> HOLD_BG, a 19200-pixel bg model drawn, seq_done pulses for exactly 1 cycle, then IDLE.
- stage_clear_req pulsed during DRAW_BG -> ignored; no second banner runs after FINISH.
- With BANNER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 20, no key -> leaves WAIT_KEY 20 cycles after entry; without the macro -> remains in WAIT_KEY past 1000 cycles.

Source files
------------

// File: rtl/draw_screen_sequencer.sv
// draw_screen_sequencer: runs the selected stage-clear banner engine, waits for the continue key,
// then redraws the background, owning the VGA adapter plot/x/y/colour inputs throughout.
// Optional feature macro: BANNER_TIMEOUT_EN (auto-continue from WAIT_KEY after TIMEOUT_CYCLES).
module draw_screen_sequencer #(
    parameter int PLOT_LAG       = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       stage_clear_req,
    input  logic       stage_sel,
    input  logic       key_continue,
    input  logic       s1_done,
    input  logic       s2_done,
    input  logic       bg_done,
    input  logic [7:0] s1_x,
    input  logic [7:0] s2_x,
    input  logic [7:0] bg_x,
    input  logic [6:0] s1_y,
    input  logic [6:0] s2_y,
    input  logic [6:0] bg_y,
    input  logic [8:0] s1_colour,
    input  logic [8:0] s2_colour,
    input  logic [8:0] bg_colour,
    output logic       s1_resetn,
    output logic       s2_resetn,
    output logic       bg_resetn,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [8:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       seq_done
);
    localparam int LW = $clog2(PLOT_LAG + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HOLD_BNR, DRAW_BNR, WAIT_KEY, HOLD_BG, DRAW_BG, FINISH} state_t;

    state_t        state;
    state_t        state_nx;
    logic          sel_r;
    logic          key_prev;
    logic [LW-1:0] lag_cnt;
    logic [HW-1:0] hold_cnt;
    logic          drawing;
    logic          holding;
    logic          hold_end;
    logic          eng_done;
    logic          key_rise;
    logic          wait_exit;

`ifdef BANNER_TIMEOUT_EN
    logic [25:0] tmo_cnt;

    // Timeout counter: runs only while staying in WAIT_KEY, cleared on every entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= (state == WAIT_KEY && state_nx == WAIT_KEY) ? tmo_cnt + 26'd1 : '0;
        end
    end

    assign wait_exit = key_rise || (tmo_cnt == 26'(TIMEOUT_CYCLES - 1));
`else
    assign wait_exit = key_rise;
`endif

    // Decode, engine enables, VGA mux and next-state selection.
    always_comb begin
        drawing    = (state == DRAW_BNR) || (state == DRAW_BG);
        holding    = (state == HOLD_BNR) || (state == HOLD_BG);
        hold_end   = hold_cnt == HW'(HOLD_CYCLES - 1);
        key_rise   = key_continue && !key_prev;
        eng_done   = (state == DRAW_BG) ? bg_done : (sel_r ? s2_done : s1_done);
        s1_resetn  = (state == DRAW_BNR) && !sel_r;
        s2_resetn  = (state == DRAW_BNR) && sel_r;
        bg_resetn  = (state == DRAW_BG);
        vga_plot   = drawing && (lag_cnt == LW'(PLOT_LAG));
        vga_x      = (state == DRAW_BG) ? bg_x : (state == DRAW_BNR) ? (sel_r ? s2_x : s1_x) : '0;
        vga_y      = (state == DRAW_BG) ? bg_y : (state == DRAW_BNR) ? (sel_r ? s2_y : s1_y) : '0;
        vga_colour = (state == DRAW_BG) ? bg_colour :
                     (state == DRAW_BNR) ? (sel_r ? s2_colour : s1_colour) : '0;
        busy       = state != IDLE;
        seq_done   = state == FINISH;
        state_nx   = state;
        case (state)
            IDLE:     state_nx = stage_clear_req ? HOLD_BNR : IDLE;
            HOLD_BNR: state_nx = hold_end ? DRAW_BNR : HOLD_BNR;
            DRAW_BNR: state_nx = (vga_plot && eng_done) ? WAIT_KEY : DRAW_BNR;
            WAIT_KEY: state_nx = wait_exit ? HOLD_BG : WAIT_KEY;
            HOLD_BG:  state_nx = hold_end ? DRAW_BG : HOLD_BG;
            DRAW_BG:  state_nx = (vga_plot && eng_done) ? FINISH : DRAW_BG;
            default:  state_nx = IDLE;
        endcase
    end

    // State, selection latch, key history and the hold/lag counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            sel_r    <= 1'b0;
            key_prev <= 1'b0;
            hold_cnt <= '0;
            lag_cnt  <= '0;
        end else begin
            state    <= state_nx;
            key_prev <= key_continue;
            if (state == IDLE && stage_clear_req) sel_r <= stage_sel;
            hold_cnt <= (holding && !hold_end) ? hold_cnt + 1'b1 : '0;
            lag_cnt  <= (drawing && state_nx == state) ?
                        ((lag_cnt == LW'(PLOT_LAG)) ? lag_cnt : lag_cnt + 1'b1) : '0;
        end
    end
endmodule

// File: tb/tb_draw_screen_sequencer.sv
// tb_draw_screen_sequencer: directed scenarios with behavioural banner/background engine models.
module tb_draw_screen_sequencer;
    logic       clk = 0;
    logic       resetn = 0;
    logic       stage_clear_req = 0;
    logic       stage_sel = 0;
    logic       key_continue = 0;
    logic       s1_done, s2_done, bg_done;
    logic [7:0] s1_x, s2_x, bg_x;
    logic [6:0] s1_y, s2_y, bg_y;
    logic [8:0] s1_colour, s2_colour, bg_colour;
    logic       s1_resetn, s2_resetn, bg_resetn;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [8:0] vga_colour;
    logic       vga_plot, busy, seq_done;

    int errors = 0;
    int checks = 0;
    int c1 = 0, c2 = 0, cb = 0;
    int i1, i2, ib;
    logic stale1 = 0;

    int which, ex_x0, ex_y0, ex_w, ex_mul;
    int plots, pix_bad, s1_hi, s2_hi, bg_hi, pulses;
    int fx, fy, lx, ly;
    logic ldone;

    always #5 clk = ~clk;

`ifdef BANNER_TIMEOUT_EN
    draw_screen_sequencer #(.TIMEOUT_CYCLES(20)) dut (
`else
    draw_screen_sequencer dut (
`endif
        .clk(clk), .resetn(resetn), .stage_clear_req(stage_clear_req), .stage_sel(stage_sel),
        .key_continue(key_continue), .s1_done(s1_done), .s2_done(s2_done), .bg_done(bg_done),
        .s1_x(s1_x), .s2_x(s2_x), .bg_x(bg_x), .s1_y(s1_y), .s2_y(s2_y), .bg_y(bg_y),
        .s1_colour(s1_colour), .s2_colour(s2_colour), .bg_colour(bg_colour),
        .s1_resetn(s1_resetn), .s2_resetn(s2_resetn), .bg_resetn(bg_resetn),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .seq_done(seq_done)
    );

    // Engine models: first valid pixel two cycles after resetn release.
    always @(posedge clk or negedge s1_resetn) if (!s1_resetn) c1 <= 0; else c1 <= c1 + 1;
    always @(posedge clk or negedge s2_resetn) if (!s2_resetn) c2 <= 0; else c2 <= c2 + 1;
    always @(posedge clk or negedge bg_resetn) if (!bg_resetn) cb <= 0; else cb <= cb + 1;

    assign i1 = c1 >= 2 ? c1 - 2 : 0;
    assign i2 = c2 >= 2 ? c2 - 2 : 0;
    assign ib = cb >= 2 ? cb - 2 : 0;
    assign s1_x = 8'(10 + i1 % 80);
    assign s1_y = 7'(20 + i1 / 80);
    assign s1_colour = 9'(i1 * 7);
    assign s1_done = (c1 >= 2 && i1 >= 3199) || (c1 < 2 && stale1);
    assign s2_x = 8'(39 + i2 % 80);
    assign s2_y = 7'(39 + i2 / 80);
    assign s2_colour = 9'(i2 * 3);
    assign s2_done = c2 >= 2 && i2 >= 3199;
    assign bg_x = 8'(ib % 160);
    assign bg_y = 7'(ib / 160);
    assign bg_colour = 9'(ib * 5);
    assign bg_done = cb >= 2 && ib >= 19199;

    // Plot/enable monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (vga_plot) begin
            if (plots == 0) begin fx = vga_x; fy = vga_y; end
            lx = vga_x;
            ly = vga_y;
            ldone = (which == 0) ? s1_done : (which == 1) ? s2_done : bg_done;
            if (vga_x !== 8'(ex_x0 + plots % ex_w) || vga_y !== 7'(ex_y0 + plots / ex_w) ||
                vga_colour !== 9'(plots * ex_mul)) pix_bad++;
            plots++;
        end
        if (s1_resetn) s1_hi++;
        if (s2_resetn) s2_hi++;
        if (bg_resetn) bg_hi++;
        if (seq_done) pulses++;
    end

    task automatic clr(input int w, input int x0, input int y0, input int wd, input int mul);
        which = w; ex_x0 = x0; ex_y0 = y0; ex_w = wd; ex_mul = mul;
        plots = 0; pix_bad = 0; s1_hi = 0; s2_hi = 0; bg_hi = 0; pulses = 0;
        fx = -1; fy = -1; lx = -1; ly = -1; ldone = 0;
    endtask

    task automatic request(input logic sel);
        @(negedge clk);
        stage_sel = sel;
        stage_clear_req = 1;
        @(negedge clk);
        stage_clear_req = 0;
        stage_sel = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", vga_plot); end
        checks++; if ({s1_resetn, s2_resetn, bg_resetn} !== 3'b000) begin errors++; $display("FAIL reset_engines: got %b want 000", {s1_resetn, s2_resetn, bg_resetn}); end
        checks++; if ({busy, seq_done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b want 00", {busy, seq_done}); end
        checks++; if ({vga_x, vga_y, vga_colour} !== 24'h0) begin errors++; $display("FAIL reset_xyc: got %h want 0", {vga_x, vga_y, vga_colour}); end
        resetn = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_banner_s2();
        int n;
        clr(1, 39, 39, 80, 3);
        request(1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!(vga_plot && s2_done) && n < 5000);
        #1;
        checks++; if (plots !== 3200) begin errors++; $display("FAIL s2_plots: got %0d want 3200", plots); end
        checks++; if (fx !== 39 || fy !== 39) begin errors++; $display("FAIL s2_first: got (%0d,%0d) want (39,39)", fx, fy); end
        checks++; if (lx !== 118 || ly !== 78 || ldone !== 1'b1) begin errors++; $display("FAIL s2_last: got (%0d,%0d) done=%b want (118,78) done=1", lx, ly, ldone); end
        checks++; if (s1_hi !== 0 || s2_hi !== 3202) begin errors++; $display("FAIL s2_enables: got s1=%0d s2=%0d want 0 3202", s1_hi, s2_hi); end
        checks++; if (pix_bad !== 0) begin errors++; $display("FAIL s2_pixels: got %0d bad want 0", pix_bad); end
        @(negedge clk);
        checks++; if ({busy, s2_resetn, vga_plot, vga_x} !== {3'b100, 8'h0}) begin errors++; $display("FAIL s2_wait_key: got busy=%b s2_resetn=%b plot=%b x=%0d want 1 0 0 0", busy, s2_resetn, vga_plot, vga_x); end
    endtask

    task automatic test_wait_timeout();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bg_resetn && n < 1100);
`ifdef BANNER_TIMEOUT_EN
        checks++; if (n !== 22) begin errors++; $display("FAIL timeout_exit: got %0d cycles want 22", n); end
`else
        checks++; if (bg_resetn !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL no_timeout: got bg_resetn=%b busy=%b want 0 1", bg_resetn, busy); end
        key_continue = 1;
`endif
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 25000);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_drain: got busy=%b want 0", busy); end
        key_continue = 0;
    endtask

    task automatic test_key_and_bg();
        int n;
        logic bad;
        stale1 = 1;
        key_continue = 1;
        clr(0, 10, 20, 80, 7);
        request(1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(vga_plot && s1_done) && n < 5000);
        #1;
        checks++; if (plots !== 3200) begin errors++; $display("FAIL s1_plots_stale: got %0d want 3200", plots); end
        checks++; if (s1_hi !== 3202 || s2_hi !== 0) begin errors++; $display("FAIL s1_enables: got s1=%0d s2=%0d want 3202 0", s1_hi, s2_hi); end
        checks++; if (fx !== 10 || fy !== 20 || lx !== 89 || ly !== 59) begin errors++; $display("FAIL s1_corners: got (%0d,%0d)-(%0d,%0d) want (10,20)-(89,59)", fx, fy, lx, ly); end
        checks++; if (pix_bad !== 0) begin errors++; $display("FAIL s1_pixels: got %0d bad want 0", pix_bad); end
        bad = 0;
        repeat (10) begin @(negedge clk); if (bg_resetn !== 1'b0 || busy !== 1'b1) bad = 1; end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL key_held: got early exit=%b want 0", bad); end
        clr(2, 0, 0, 160, 5);
        key_continue = 0;
        @(negedge clk);
        key_continue = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bg_resetn && n < 20);
        checks++; if (n !== 3) begin errors++; $display("FAIL key_to_bg: got %0d cycles want 3", n); end
        @(negedge clk);
        stage_sel = 1;
        stage_clear_req = 1;
        @(negedge clk);
        stage_clear_req = 0;
        stage_sel = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!seq_done && n < 25000);
        #1;
        checks++; if (plots !== 19200) begin errors++; $display("FAIL bg_plots: got %0d want 19200", plots); end
        checks++; if (bg_hi !== 19202 || lx !== 159 || ly !== 119 || ldone !== 1'b1) begin errors++; $display("FAIL bg_run: got en=%0d last=(%0d,%0d) done=%b want 19202 (159,119) 1", bg_hi, lx, ly, ldone); end
        checks++; if (pix_bad !== 0) begin errors++; $display("FAIL bg_pixels: got %0d bad want 0", pix_bad); end
        @(negedge clk);
        checks++; if ({busy, seq_done} !== 2'b00) begin errors++; $display("FAIL finish_idle: got busy=%b seq_done=%b want 0 0", busy, seq_done); end
        repeat (200) @(negedge clk);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL seq_done_pulse: got %0d cycles want 1", pulses); end
        checks++; if (s1_hi !== 0 || s2_hi !== 0 || busy !== 1'b0) begin errors++; $display("FAIL req_ignored: got s1=%0d s2=%0d busy=%b want 0 0 0", s1_hi, s2_hi, busy); end
        key_continue = 0;
        stale1 = 0;
    endtask

    task automatic test_reset_mid_draw();
        int n;
        clr(0, 10, 20, 80, 7);
        request(1'b0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (plots < 100 && n < 5000);
        checks++; if (vga_plot !== 1'b1 || s1_resetn !== 1'b1) begin errors++; $display("FAIL mid_draw_active: got plot=%b s1_resetn=%b want 1 1", vga_plot, s1_resetn); end
        resetn = 0;
        #1;
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL abort_plot: got %b want 0", vga_plot); end
        checks++; if ({s1_resetn, s2_resetn, bg_resetn, busy} !== 4'b0000) begin errors++; $display("FAIL abort_engines: got %b want 0000", {s1_resetn, s2_resetn, bg_resetn, busy}); end
        @(negedge clk);
        checks++; if ({vga_x, vga_y, vga_colour} !== 24'h0) begin errors++; $display("FAIL abort_xyc: got %h want 0", {vga_x, vga_y, vga_colour}); end
        resetn = 1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || vga_plot !== 1'b0) begin errors++; $display("FAIL after_abort: got busy=%b plot=%b want 0 0", busy, vga_plot); end
    endtask

    initial begin
        clr(0, 0, 0, 80, 1);
        test_reset();
        test_banner_s2();
        test_wait_timeout();
        test_key_and_bg();
        test_reset_mid_draw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
